lookahead_carry_generator: RTL and testbench

Registered 4-bit carry-lookahead generator for the ALU adder tree. From per-bit propagate/generate signals and a carry-in, it computes the internal carries c1..c3 and the group propagate/generate pair. The next lookahead level or the ripple-free adder sum stage consumes these outputs. Outputs are captured in a single register stage so the block fits the single-clock ALU pipeline.

---
 rtl/lookahead_carry_generator.sv | 76 +++++++
 tb/tb_lookahead_carry_generator.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lookahead_carry_generator.sv
// Registered 4-bit carry-lookahead generator: internal carries c[3:1] plus group
// propagate/generate for the next lookahead level, with one register stage.

module lookahead_carry_generator (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       c0,
   output logic       P,
   output logic       G,
   output logic [3:1] c,
   output logic       out_valid
);

   logic       grp_p_d;
   logic       grp_g_d;
   logic [3:1] carry_d;

   logic       grp_p_q;
   logic       grp_g_q;
   logic [3:1] carry_q;
   logic       valid_q;

   // Every carry is a flat sum of products; no carry feeds the next one, so all
   // three settle in two gate levels regardless of bit position.
   always_comb begin
      carry_d    = '0;
      carry_d[1] = g[0]
                 | (p[0] & c0);
      carry_d[2] = g[1]
                 | (p[1] & g[0])
                 | (p[1] & p[0] & c0);
      carry_d[3] = g[2]
                 | (p[2] & g[1])
                 | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c0);
   end

   // Group terms are independent of c0 so the next level can resolve c4 = G | P & c0.
   always_comb begin
      grp_p_d = p[3] & p[2] & p[1] & p[0];
      grp_g_d = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
   end

   // Result registers load only on in_valid, so garbage on idle cycles never lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_p_q <= 1'b0;
         grp_g_q <= 1'b0;
         carry_q <= '0;
      end else if (in_valid) begin
         grp_p_q <= grp_p_d;
         grp_g_q <= grp_g_d;
         carry_q <= carry_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
      end
   end

   assign P         = grp_p_q;
   assign G         = grp_g_q;
   assign c         = carry_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_lookahead_carry_generator.sv
// Directed bench for lookahead_carry_generator; compares {out_valid,P,G,c[3:1]}
// against hand-computed values.

module tb_lookahead_carry_generator;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] p;
   logic [3:0] g;
   logic       c0;
   logic       P;
   logic       G;
   logic [3:1] c;
   logic       out_valid;

   int total;
   int bad;

   lookahead_carry_generator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .p         (p),
      .g         (g),
      .c0        (c0),
      .P         (P),
      .G         (G),
      .c         (c),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed as {out_valid, P, G, c[3:1]}.
   task automatic check(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {out_valid, P, G, c};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed={v,P,G,c}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic vld, input logic [3:0] pv, input logic [3:0] gv,
                       input logic cv);
      @(negedge clk);
      in_valid = vld;
      p        = pv;
      g        = gv;
      c0       = cv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      p        = '0;
      g        = '0;
      c0       = 1'b0;
      #1;
      check("reset", 6'b0_0_0_000);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      check("all_zero", 6'b1_0_0_000);

      step(1'b1, 4'b0010, 4'b0010, 1'b0);
      check("g1_only", 6'b1_0_0_010);

      step(1'b1, 4'b1100, 4'b0011, 1'b0);
      check("mixed_pg", 6'b1_0_1_111);

      step(1'b1, 4'b1111, 4'b1111, 1'b1);
      check("all_one", 6'b1_1_1_111);

      step(1'b1, 4'b1111, 4'b0000, 1'b1);
      check("prop_c0_1", 6'b1_1_0_111);

      step(1'b1, 4'b1111, 4'b0000, 1'b0);
      check("prop_c0_0", 6'b1_1_0_000);

      step(1'b1, 4'b0001, 4'b0000, 1'b1);
      check("c1_only", 6'b1_0_0_001);

      step(1'b1, 4'b0111, 4'b0000, 1'b1);
      check("c0_ripple", 6'b1_0_0_111);

      // g without p is legal; c0 must not leak into G.
      step(1'b1, 4'b0000, 4'b1000, 1'b1);
      check("g3_no_p", 6'b1_0_1_000);

      step(1'b1, 4'b1110, 4'b0001, 1'b0);
      check("g0_chain", 6'b1_0_1_111);

      step(1'b1, 4'b1111, 4'b0000, 1'b1);
      check("reload", 6'b1_1_0_111);

      step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      check("hold_rand", 6'b0_1_0_111);

      step(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
      check("hold_x", 6'b0_1_0_111);

      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      check("after_hold", 6'b1_0_0_000);

      step(1'b1, 4'b1111, 4'b1111, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 6'b0_0_0_000);

      @(posedge clk);
      #1;
      check("rst_held", 6'b0_0_0_000);

      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      p        = 4'b1100;
      g        = 4'b0011;
      c0       = 1'b0;
      @(posedge clk);
      #1;
      check("first_edge", 6'b1_0_1_111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
